// File: rtl/if_id_pipe.sv
// IF/ID pipeline register: captures fetch PC/next PC/instruction and raises load-use stall, flush bubble and sticky halt.
// Optional feature macro IF_ID_PERF_EN adds saturating stall_count/flush_count outputs.
module if_id_pipe (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] if_pc,
    input  logic [15:0] if_next_pc,
    input  logic [15:0] if_instr,
    input  logic        flush,
    input  logic        ex_mem_read,
    input  logic [3:0]  ex_rd,
    output logic [15:0] id_pc,
    output logic [15:0] id_next_pc,
    output logic [15:0] id_instr,
    output logic        id_valid,
    output logic        pc_hold,
    output logic        id_bubble,
`ifdef IF_ID_PERF_EN
    output logic [15:0] stall_count,
    output logic [15:0] flush_count,
`endif
    output logic        halted
);

    logic [15:0] pc_q, pc_d;
    logic [15:0] npc_q, npc_d;
    logic [15:0] instr_q, instr_d;
    logic        valid_q, valid_d;

    logic [3:0]  opc, rd_f, rs_f, rt_f;
    logic        use_rs, use_rt, use_rd, src_match;
    logic        load_use, halt_hit;

    always_comb begin
        opc    = instr_q[15:12];
        rd_f   = instr_q[11:8];
        rs_f   = instr_q[7:4];
        rt_f   = instr_q[3:0];
        use_rs = (opc <= 4'h9) || (opc == 4'hD);
        use_rt = (opc <= 4'h3) || (opc == 4'h7);
        use_rd = (opc == 4'h9) || (opc == 4'hA) || (opc == 4'hB);
        src_match = (use_rs && (rs_f == ex_rd)) ||
                    (use_rt && (rt_f == ex_rd)) ||
                    (use_rd && (rd_f == ex_rd));
        // R0 reads as zero, so a load targeting it can never feed a consumer.
        load_use = valid_q && ex_mem_read && (ex_rd != 4'h0) && src_match;
        halt_hit = valid_q && (opc == 4'hF);
    end

    assign pc_hold    = (load_use || halt_hit) && !flush;
    assign id_bubble  = load_use || flush;
    assign halted     = halt_hit && !flush;
    assign id_pc      = pc_q;
    assign id_next_pc = npc_q;
    assign id_instr   = instr_q;
    assign id_valid   = valid_q;

    always_comb begin
        pc_d    = pc_q;
        npc_d   = npc_q;
        instr_d = instr_q;
        valid_d = valid_q;
        if (flush) begin
            pc_d    = 16'h0000;
            npc_d   = 16'h0000;
            instr_d = 16'h0000;
            valid_d = 1'b0;
        end else if (!halt_hit && !load_use) begin
            pc_d    = if_pc;
            npc_d   = if_next_pc;
            instr_d = if_instr;
            valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q    <= 16'h0000;
            npc_q   <= 16'h0000;
            instr_q <= 16'h0000;
            valid_q <= 1'b0;
        end else begin
            pc_q    <= pc_d;
            npc_q   <= npc_d;
            instr_q <= instr_d;
            valid_q <= valid_d;
        end
    end

`ifdef IF_ID_PERF_EN
    logic [15:0] stall_cnt_q, stall_cnt_d;
    logic [15:0] flush_cnt_q, flush_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        flush_cnt_d = flush_cnt_q;
        if (load_use && !flush && (stall_cnt_q != 16'hFFFF)) begin
            stall_cnt_d = stall_cnt_q + 16'd1;
        end
        if (flush && (flush_cnt_q != 16'hFFFF)) begin
            flush_cnt_d = flush_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stall_cnt_q <= 16'h0000;
            flush_cnt_q <= 16'h0000;
        end else begin
            stall_cnt_q <= stall_cnt_d;
            flush_cnt_q <= flush_cnt_d;
        end
    end

    assign stall_count = stall_cnt_q;
    assign flush_count = flush_cnt_q;
`endif

endmodule

// File: tb/tb_if_id_pipe.sv
// Self-checking bench for if_id_pipe: scoreboard of expected IF/ID contents plus inline hazard-signal checks.
module tb_if_id_pipe;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] if_pc = '0, if_next_pc = '0, if_instr = '0;
    logic        flush = 1'b0, ex_mem_read = 1'b0;
    logic [3:0]  ex_rd = '0;
    logic [15:0] id_pc, id_next_pc, id_instr;
    logic        id_valid, pc_hold, id_bubble, halted;
`ifdef IF_ID_PERF_EN
    logic [15:0] stall_count, flush_count;
`endif

    typedef struct packed {
        logic        v;
        logic [15:0] pc;
        logic [15:0] npc;
        logic [15:0] instr;
    } ent_t;

    ent_t sb[$];
    ent_t exp_e, got_e;
    int   checks = 0;
    int   errors = 0;

    if_id_pipe dut (
        .clk(clk), .rst_n(rst_n),
        .if_pc(if_pc), .if_next_pc(if_next_pc), .if_instr(if_instr),
        .flush(flush), .ex_mem_read(ex_mem_read), .ex_rd(ex_rd),
        .id_pc(id_pc), .id_next_pc(id_next_pc), .id_instr(id_instr),
        .id_valid(id_valid), .pc_hold(pc_hold), .id_bubble(id_bubble),
`ifdef IF_ID_PERF_EN
        .stall_count(stall_count), .flush_count(flush_count),
`endif
        .halted(halted)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [15:0] pc, input logic [15:0] instr);
        if_pc      = pc;
        if_next_pc = pc + 16'd2;
        if_instr   = instr;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        fetch(16'h1234, 16'hF000);
        ex_mem_read = 1'b1;
        ex_rd = 4'h3;
        tick;
        tick;
        #1;
        checks++;
        if ({id_valid, id_pc, id_next_pc, id_instr} !== 49'h0) begin
            errors++;
            $display("FAIL reset_regs got %h required 0", {id_valid, id_pc, id_next_pc, id_instr});
        end
        checks++;
        if ({pc_hold, id_bubble, halted} !== 3'b000) begin
            errors++;
            $display("FAIL reset_comb got %b required 000", {pc_hold, id_bubble, halted});
        end
        ex_mem_read = 1'b0;
        ex_rd = 4'h0;
    endtask

    task automatic test_straight_line;
        logic [15:0] instrs [3];
        instrs[0] = 16'h5100;
        instrs[1] = 16'h6211;
        instrs[2] = 16'hC322;
        rst_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            fetch(16'(2 * i), instrs[i]);
            sb.push_back('{1'b1, 16'(2 * i), 16'(2 * i + 2), instrs[i]});
            tick;
            exp_e = sb.pop_front();
            got_e = {id_valid, id_pc, id_next_pc, id_instr};
            checks++;
            if (got_e !== exp_e) begin
                errors++;
                $display("FAIL straight_%0d got %h required %h", i, got_e, exp_e);
            end
        end
    endtask

    task automatic test_load_use_rs;
        fetch(16'h0010, 16'h1234);
        sb.push_back('{1'b1, 16'h0010, 16'h0012, 16'h1234});
        tick;
        exp_e = sb.pop_front();
        got_e = {id_valid, id_pc, id_next_pc, id_instr};
        checks++;
        if (got_e !== exp_e) begin
            errors++;
            $display("FAIL lu_load got %h required %h", got_e, exp_e);
        end
        fetch(16'h0012, 16'h6000);
        ex_mem_read = 1'b1;
        ex_rd = 4'h3;
        #1;
        checks++;
        if ({pc_hold, id_bubble} !== 2'b11) begin
            errors++;
            $display("FAIL lu_stall got %b required 11", {pc_hold, id_bubble});
        end
        sb.push_back('{1'b1, 16'h0010, 16'h0012, 16'h1234});
        tick;
        exp_e = sb.pop_front();
        got_e = {id_valid, id_pc, id_next_pc, id_instr};
        checks++;
        if (got_e !== exp_e) begin
            errors++;
            $display("FAIL lu_hold got %h required %h", got_e, exp_e);
        end
        ex_mem_read = 1'b0;
        #1;
        checks++;
        if ({pc_hold, id_bubble} !== 2'b00) begin
            errors++;
            $display("FAIL lu_release got %b required 00", {pc_hold, id_bubble});
        end
        sb.push_back('{1'b1, 16'h0012, 16'h0014, 16'h6000});
        tick;
        exp_e = sb.pop_front();
        got_e = {id_valid, id_pc, id_next_pc, id_instr};
        checks++;
        if (got_e !== exp_e) begin
            errors++;
            $display("FAIL lu_next got %h required %h", got_e, exp_e);
        end
    endtask

    // Source-use decode table: instruction in ID, load destination, expected hazard.
    task automatic test_hazard_decode;
        logic [15:0] ins [9];
        logic [3:0]  rdv [9];
        logic        hz  [9];
        ins[0] = 16'h1234; rdv[0] = 4'h3; hz[0] = 1'b1;
        ins[1] = 16'h1234; rdv[1] = 4'h4; hz[1] = 1'b1;
        ins[2] = 16'h1234; rdv[2] = 4'h2; hz[2] = 1'b0;
        ins[3] = 16'h4235; rdv[3] = 4'h5; hz[3] = 1'b0;
        ins[4] = 16'h4235; rdv[4] = 4'h3; hz[4] = 1'b1;
        ins[5] = 16'h9A00; rdv[5] = 4'hA; hz[5] = 1'b1;
        ins[6] = 16'hC567; rdv[6] = 4'h5; hz[6] = 1'b0;
        ins[7] = 16'hD560; rdv[7] = 4'h6; hz[7] = 1'b1;
        ins[8] = 16'h7000; rdv[8] = 4'h0; hz[8] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            ex_mem_read = 1'b0;
            fetch(16'h0100 + 16'(2 * i), ins[i]);
            sb.push_back('{1'b1, 16'h0100 + 16'(2 * i), 16'h0102 + 16'(2 * i), ins[i]});
            tick;
            exp_e = sb.pop_front();
            got_e = {id_valid, id_pc, id_next_pc, id_instr};
            checks++;
            if (got_e !== exp_e) begin
                errors++;
                $display("FAIL dec_load_%0d got %h required %h", i, got_e, exp_e);
            end
            ex_mem_read = 1'b1;
            ex_rd = rdv[i];
            #1;
            checks++;
            if ({pc_hold, id_bubble} !== {hz[i], hz[i]}) begin
                errors++;
                $display("FAIL dec_hazard_%0d got %b required %b", i, {pc_hold, id_bubble}, {hz[i], hz[i]});
            end
        end
        ex_mem_read = 1'b0;
        ex_rd = 4'h0;
    endtask

    task automatic test_flush_over_stall;
        fetch(16'h0200, 16'h1234);
        sb.push_back('{1'b1, 16'h0200, 16'h0202, 16'h1234});
        tick;
        exp_e = sb.pop_front();
        got_e = {id_valid, id_pc, id_next_pc, id_instr};
        checks++;
        if (got_e !== exp_e) begin
            errors++;
            $display("FAIL fl_load got %h required %h", got_e, exp_e);
        end
        ex_mem_read = 1'b1;
        ex_rd = 4'h3;
        flush = 1'b1;
        #1;
        checks++;
        if ({pc_hold, id_bubble, halted} !== 3'b010) begin
            errors++;
            $display("FAIL fl_comb got %b required 010", {pc_hold, id_bubble, halted});
        end
        sb.push_back('{1'b0, 16'h0, 16'h0, 16'h0});
        tick;
        flush = 1'b0;
        ex_mem_read = 1'b0;
        exp_e = sb.pop_front();
        got_e = {id_valid, id_pc, id_next_pc, id_instr};
        checks++;
        if (got_e !== exp_e) begin
            errors++;
            $display("FAIL fl_bubble got %h required %h", got_e, exp_e);
        end
    endtask

    task automatic test_halt;
        fetch(16'h0300, 16'hF000);
        sb.push_back('{1'b1, 16'h0300, 16'h0302, 16'hF000});
        tick;
        for (int i = 0; i < 12; i++) begin
            if_pc       = 16'($urandom);
            if_next_pc  = 16'($urandom);
            if_instr    = 16'($urandom);
            ex_mem_read = 1'($urandom);
            ex_rd       = 4'($urandom);
            #1;
            exp_e = sb.pop_front();
            got_e = {id_valid, id_pc, id_next_pc, id_instr};
            checks++;
            if (got_e !== exp_e || halted !== 1'b1 || pc_hold !== 1'b1) begin
                errors++;
                $display("FAIL halt_hold_%0d got %h h%b p%b required %h h1 p1", i, got_e, halted, pc_hold, exp_e);
            end
            sb.push_back(exp_e);
            tick;
        end
        exp_e = sb.pop_front();
        ex_mem_read = 1'b0;
        flush = 1'b1;
        #1;
        checks++;
        if ({halted, pc_hold, id_bubble} !== 3'b001) begin
            errors++;
            $display("FAIL halt_flush got %b required 001", {halted, pc_hold, id_bubble});
        end
        sb.push_back('{1'b0, 16'h0, 16'h0, 16'h0});
        tick;
        flush = 1'b0;
        exp_e = sb.pop_front();
        got_e = {id_valid, id_pc, id_next_pc, id_instr};
        checks++;
        if (got_e !== exp_e || halted !== 1'b0) begin
            errors++;
            $display("FAIL halt_squashed got %h h%b required %h h0", got_e, halted, exp_e);
        end
        fetch(16'h0400, 16'h2123);
        sb.push_back('{1'b1, 16'h0400, 16'h0402, 16'h2123});
        tick;
        exp_e = sb.pop_front();
        got_e = {id_valid, id_pc, id_next_pc, id_instr};
        checks++;
        if (got_e !== exp_e) begin
            errors++;
            $display("FAIL halt_resume got %h required %h", got_e, exp_e);
        end
    endtask

    task automatic test_halt_reset;
        fetch(16'h0500, 16'hF123);
        tick;
        #1;
        checks++;
        if (halted !== 1'b1) begin
            errors++;
            $display("FAIL hr_halted got %b required 1", halted);
        end
        rst_n = 1'b0;
        tick;
        checks++;
        if ({halted, pc_hold, id_valid, id_instr} !== 19'h0) begin
            errors++;
            $display("FAIL hr_cleared got %h required 0", {halted, pc_hold, id_valid, id_instr});
        end
        rst_n = 1'b1;
    endtask

    task automatic test_back_to_back;
        logic [15:0] pc, ins;
        for (int i = 0; i < 20; i++) begin
            pc  = 16'($urandom);
            ins = {4'($urandom_range(0, 14)), 12'($urandom)};
            fetch(pc, ins);
            sb.push_back('{1'b1, pc, pc + 16'd2, ins});
            tick;
            exp_e = sb.pop_front();
            got_e = {id_valid, id_pc, id_next_pc, id_instr};
            checks++;
            if (got_e !== exp_e) begin
                errors++;
                $display("FAIL b2b_%0d got %h required %h", i, got_e, exp_e);
            end
        end
    endtask

`ifdef IF_ID_PERF_EN
    task automatic test_perf;
        rst_n = 1'b0;
        tick;
        rst_n = 1'b1;
        checks++;
        if ({stall_count, flush_count} !== 32'h0) begin
            errors++;
            $display("FAIL perf_reset got %h required 0", {stall_count, flush_count});
        end
        for (int i = 0; i < 3; i++) begin
            fetch(16'h0600, 16'h1234);
            tick;
            ex_mem_read = 1'b1;
            ex_rd = 4'h3;
            tick;
            ex_mem_read = 1'b0;
        end
        for (int i = 0; i < 2; i++) begin
            flush = 1'b1;
            tick;
            flush = 1'b0;
        end
        checks++;
        if (stall_count !== 16'd3 || flush_count !== 16'd2) begin
            errors++;
            $display("FAIL perf_counts got %0d/%0d required 3/2", stall_count, flush_count);
        end
        fetch(16'h0700, 16'h1234);
        tick;
        force dut.stall_cnt_q = 16'hFFFF;
        #1;
        release dut.stall_cnt_q;
        ex_mem_read = 1'b1;
        ex_rd = 4'h3;
        tick;
        ex_mem_read = 1'b0;
        checks++;
        if (stall_count !== 16'hFFFF) begin
            errors++;
            $display("FAIL perf_saturate got %h required ffff", stall_count);
        end
    endtask
`endif

    initial begin
        test_reset;
        test_straight_line;
        test_load_use_rs;
        test_hazard_decode;
        test_flush_over_stall;
        test_halt;
        test_halt_reset;
        test_back_to_back;
`ifdef IF_ID_PERF_EN
        test_perf;
`endif
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
